// File: rtl/microwave_cook_timer_if.sv
// Signal bundle between the cook timer and its environment:
// buttons and heat in, start/finish pulse/level and BCD time out.
interface microwave_cook_timer_if;
    logic       btn_10s;
    logic       btn_1m;
    logic       btn_clear;
    logic       btn_start;
    logic       heat;
    logic       start;
    logic       finish;
    logic       running;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;

    modport master (
        output btn_10s, btn_1m, btn_clear, btn_start, heat,
        input  start, finish, running, min_t, min_o, sec_t, sec_o
    );

    modport slave (
        input  btn_10s, btn_1m, btn_clear, btn_start, heat,
        output start, finish, running, min_t, min_o, sec_t, sec_o
    );
endinterface

// File: rtl/microwave_cook_timer.sv
// Microwave cook timer: BCD mm:ss programmed by buttons, counted down while
// the controller drives heat, with a start pulse and a held finish level.
module microwave_cook_timer #(
    parameter int TICKS_PER_SEC = 1000
) (
    input logic                    clk,
    input logic                    nrst,
    microwave_cook_timer_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '0;
    localparam bcd_time_t TIME_ONE  = '{mt: 4'd0, mo: 4'd0, st: 4'd0, so: 4'd1};

    // ---------------------------------------------------------------
    // BCD arithmetic helpers
    // ---------------------------------------------------------------
    function automatic bcd_time_t inc_min(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.mo == 4'd9) begin
            r.mo = 4'd0;
            r.mt = t.mt + 4'd1;
        end else begin
            r.mo = t.mo + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_time_t add_1m(input bcd_time_t t);
        if (t.mt == 4'd9 && t.mo == 4'd9)
            return t;
        return inc_min(t);
    endfunction

    // Seconds tens only reaches 5, so a carry happens exactly when st is 5.
    function automatic bcd_time_t add_10s(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.mt == 4'd9 && t.mo == 4'd9 && t.st == 4'd5) begin
            r.so = 4'd9;
        end else if (t.st == 4'd5) begin
            r.st = 4'd0;
            r = inc_min(r);
        end else begin
            r.st = t.st + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_time_t dec_1s(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.st != 4'd0 || t.so != 4'd0) begin
            if (t.so == 4'd0) begin
                r.so = 4'd9;
                r.st = t.st - 4'd1;
            end else begin
                r.so = t.so - 4'd1;
            end
        end else begin
            r.st = 4'd5;
            r.so = 4'd9;
            if (t.mo == 4'd0) begin
                r.mo = 4'd9;
                r.mt = t.mt - 4'd1;
            end else begin
                r.mo = t.mo - 4'd1;
            end
        end
        return r;
    endfunction

    // ---------------------------------------------------------------
    // Button edge detection
    // ---------------------------------------------------------------
    logic [3:0] btn_now;
    logic [3:0] btn_q;
    logic       primed_q;
    logic [3:0] rise;

    assign btn_now = {bus.btn_start, bus.btn_clear, bus.btn_1m, bus.btn_10s};
    // primed_q masks the first cycle after reset so a button already held
    // at release is absorbed into btn_q instead of producing an event.
    assign rise    = btn_now & ~btn_q & {4{primed_q}};

    logic ev_start;
    logic do_clear;
    logic do_1m;
    logic do_10s;
    logic do_add;

    assign ev_start = rise[3];
    assign do_clear = rise[2] & ~bus.heat;
    assign do_1m    = rise[1] & ~bus.heat & ~do_clear;
    assign do_10s   = rise[0] & ~bus.heat & ~do_clear & ~do_1m;
    assign do_add   = do_1m | do_10s;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t          state_q, state_d;
    bcd_time_t       tm_q, tm_d;
    bcd_time_t       tm_edit;
    logic [PW-1:0]   presc_q, presc_d;
    logic            start_q, start_d;

    assign tm_edit = do_1m ? add_1m(tm_q) : add_10s(tm_q);

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a variable unassigned (no latch).
    always_comb begin
        state_d = state_q;
        tm_d    = tm_q;
        presc_d = presc_q;
        start_d = ev_start & ~bus.heat & (tm_q != TIME_ZERO) & (state_q != S_RUN);

        unique case (state_q)
            S_IDLE: begin
                if (do_add) begin
                    tm_d    = tm_edit;
                    state_d = S_ARMED;
                end
            end

            S_ARMED: begin
                if (do_clear) begin
                    tm_d    = TIME_ZERO;
                    presc_d = '0;
                    state_d = S_IDLE;
                end else if (do_add) begin
                    tm_d = tm_edit;
                end else if (bus.heat) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // A pause keeps the prescaler so the next run resumes mid-second.
                if (!bus.heat) begin
                    state_d = S_ARMED;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (tm_q == TIME_ONE) begin
                        tm_d    = TIME_ZERO;
                        state_d = S_DONE;
                    end else begin
                        tm_d = dec_1s(tm_q);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            S_DONE: begin
                if (do_clear) begin
                    tm_d    = TIME_ZERO;
                    presc_d = '0;
                    state_d = S_IDLE;
                end else if (do_add) begin
                    tm_d    = tm_edit;
                    state_d = S_ARMED;
                end
            end
        endcase
    end

    // NOTE: asynchronous reset clears every register, including the edge
    // detectors and the prescaler, so a mid-run reset leaves nothing stale.
    // NOTE: state registers use non-blocking assignments only, so all of
    // them update together from values computed in the previous cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            tm_q     <= TIME_ZERO;
            presc_q  <= '0;
            start_q  <= 1'b0;
            btn_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tm_q     <= tm_d;
            presc_q  <= presc_d;
            start_q  <= start_d;
            btn_q    <= btn_now;
            primed_q <= 1'b1;
        end
    end

    assign bus.start   = start_q;
    assign bus.finish  = (state_q == S_DONE);
    assign bus.running = (state_q == S_RUN);
    assign bus.min_t   = tm_q.mt;
    assign bus.min_o   = tm_q.mo;
    assign bus.sec_t   = tm_q.st;
    assign bus.sec_o   = tm_q.so;

endmodule
